// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants for the timer block family. The upstream count-down
// timer and timer_irq_ctrl both use these values, so a counter value and
// its reset state have the same meaning on both sides of the interface.
//
// Contents:
//   CNT_W      width of the timer counter value and of the compare register
//   EVT_W      width of the saturating expiry event counter
//   STS_EXP    status bit index for expiry
//   STS_CMP    status bit index for compare match
//   CNT_RST    counter reset value (all ones)
//   STRETCH_W  width of the expiry pulse stretch down-counter
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam int CNT_W = 32;
   localparam int EVT_W = 16;

   localparam int STS_EXP = 0;
   localparam int STS_CMP = 1;

   // The upstream counter resets to all ones. This block resets its
   // previous-count register to the same value, so a counter that reads 0
   // straight after reset is treated as a fresh expiry.
   localparam logic [CNT_W-1:0] CNT_RST = '1;

   // An 8-bit stretch counter allows pulse lengths from 1 to 255 cycles.
   localparam int STRETCH_W = 8;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_irq_ctrl_if
// Bundles the signals between timer_irq_ctrl and its surroundings: the
// upstream timer counter, the register block and the interrupt controller.
//
// Signals:
//   cnt          current timer counter value              (master -> slave)
//   cfg_cmp      compare value, quasi-static              (master -> slave)
//   irq_en       interrupt enables [0]=expiry [1]=compare (master -> slave)
//   sts_clr      write-1-to-clear status strobes          (master -> slave)
//   evt_clr      clear strobe for the expiry counter      (master -> slave)
//   status       sticky status [0]=expired [1]=compare    (slave -> master)
//   irq          registered interrupt line                (slave -> master)
//   expire_pulse single-cycle strobe per expiry           (slave -> master)
//   pulse_out    expiry pulse stretched to PULSE_W cycles (slave -> master)
//   evt_count    saturating expiry event count            (slave -> master)
//
// Modports:
//   master  the side that drives the counter and configuration
//   slave   timer_irq_ctrl itself
// ---------------------------------------------------------------------------
interface timer_irq_ctrl_if #(
   parameter int CNT_W = timer_pkg::CNT_W,
   parameter int EVT_W = timer_pkg::EVT_W
) ();

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cfg_cmp;
   logic [1:0]       irq_en;
   logic [1:0]       sts_clr;
   logic             evt_clr;

   logic [1:0]       status;
   logic             irq;
   logic             expire_pulse;
   logic             pulse_out;
   logic [EVT_W-1:0] evt_count;

   modport master (
      output cnt,
      output cfg_cmp,
      output irq_en,
      output sts_clr,
      output evt_clr,
      input  status,
      input  irq,
      input  expire_pulse,
      input  pulse_out,
      input  evt_count
   );

   modport slave (
      input  cnt,
      input  cfg_cmp,
      input  irq_en,
      input  sts_clr,
      input  evt_clr,
      output status,
      output irq,
      output expire_pulse,
      output pulse_out,
      output evt_count
   );

endinterface

// File: rtl/timer_pulse_stretch.sv
// ---------------------------------------------------------------------------
// timer_pulse_stretch
// Stretches a single-cycle load strobe into a pulse PULSE_W cycles long.
// A load while the pulse is still active restarts the full length, so
// back-to-back triggers give one continuous pulse with no gap.
//
// Parameters:
//   PULSE_W    pulse length in clock cycles, 1..255
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       start (or restart) the pulse
//   pulse_out  high while the down-counter is non-zero
// ---------------------------------------------------------------------------
module timer_pulse_stretch #(
   parameter int PULSE_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic pulse_out
);

   import timer_pkg::*;

   localparam logic [STRETCH_W-1:0] LOAD_VAL = STRETCH_W'(PULSE_W);
   localparam logic [STRETCH_W-1:0] ONE      = STRETCH_W'(1);

   logic [STRETCH_W-1:0] remain;

   // Counts the cycles of pulse still to be driven. A load sets the full
   // length; otherwise the counter runs down to zero and stays there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain <= '0;
      end else if (load) begin
         remain <= LOAD_VAL;
      end else if (remain != '0) begin
         remain <= remain - ONE;
      end
   end

   // Decoded only from the counter flop, so there is no path from load
   // to the output pin.
   assign pulse_out = (remain != '0);

endmodule

// File: rtl/timer_irq_ctrl.sv
// ---------------------------------------------------------------------------
// timer_irq_ctrl
// Watches the count-down timer value and turns expiry (counter reaching 0)
// and compare-match (counter reaching cfg_cmp) into sticky status bits, a
// maskable registered interrupt, a single-cycle expiry strobe, a stretched
// expiry pulse for external pins and a saturating expiry counter.
//
// Parameters:
//   CNT_W    width of the counter value and compare register
//   EVT_W    width of the saturating expiry counter
//   PULSE_W  length of pulse_out in cycles, 1..255
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      timer_irq_ctrl_if slave modport (see the interface for fields)
//
// Latency, with cycle N the first cycle in which cnt==0 is visible:
//   expire_pulse high in N+1 only, status[0] set from N+1, irq from N+2,
//   pulse_out high in N+1..N+PULSE_W. Compare match follows the same timing
//   on status[1].
// ---------------------------------------------------------------------------
module timer_irq_ctrl #(
   parameter int CNT_W   = timer_pkg::CNT_W,
   parameter int EVT_W   = timer_pkg::EVT_W,
   parameter int PULSE_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   timer_irq_ctrl_if.slave   bus
);

   import timer_pkg::*;

   localparam logic [CNT_W-1:0] CNT_RST_W = CNT_W'(CNT_RST);
   localparam logic [EVT_W-1:0] EVT_MAX   = '1;
   localparam logic [EVT_W-1:0] EVT_ONE   = EVT_W'(1);

   logic [CNT_W-1:0] cnt_d;
   logic             exp_evt;
   logic             cmp_evt;
   logic [1:0]       evt;
   logic [1:0]       status_q;
   logic             irq_q;
   logic             expire_q;
   logic [EVT_W-1:0] evt_q;
   logic             pulse;

   // Events fire only on the cycle the counter arrives at a value, never
   // while it sits there. Comparing against last cycle's count gives that
   // edge behaviour and still fires again after a reload to the same value.
   assign exp_evt = (bus.cnt == '0) && (cnt_d != '0);
   assign cmp_evt = (bus.cnt == bus.cfg_cmp) && (cnt_d != bus.cfg_cmp);

   // Pack both events into status bit order so the status update below
   // treats them uniformly.
   always_comb begin
      evt          = '0;
      evt[STS_EXP] = exp_evt;
      evt[STS_CMP] = cmp_evt;
   end

   // Previous counter value. Reset to the upstream counter's reset value so
   // a counter already at 0 after reset still produces one expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_d <= CNT_RST_W;
      end else begin
         cnt_d <= bus.cnt;
      end
   end

   // Sticky status. A new event in the same cycle as a clear strobe leaves
   // the bit set, so an interrupt that arrives during a clear is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
      end else begin
         status_q <= (status_q & ~bus.sts_clr) | evt;
      end
   end

   // Interrupt is taken from the registered status, one cycle behind it.
   // Masking only gates the line; the status bits stay set, so re-enabling
   // raises the interrupt again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(status_q & bus.irq_en);
      end
   end

   // Single-cycle expiry strobe, registered so the output has no
   // combinational path from cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expire_q <= 1'b0;
      end else begin
         expire_q <= exp_evt;
      end
   end

   // Expiry counter. It sticks at all ones rather than wrapping. A clear
   // coinciding with an expiry counts that expiry, leaving 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q <= '0;
      end else if (bus.evt_clr) begin
         evt_q <= exp_evt ? EVT_ONE : '0;
      end else if (exp_evt && (evt_q != EVT_MAX)) begin
         evt_q <= evt_q + EVT_ONE;
      end
   end

   timer_pulse_stretch #(
      .PULSE_W   (PULSE_W)
   ) u_stretch (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (exp_evt),
      .pulse_out (pulse)
   );

   assign bus.status       = status_q;
   assign bus.irq          = irq_q;
   assign bus.expire_pulse = expire_q;
   assign bus.pulse_out    = pulse;
   assign bus.evt_count    = evt_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_ctrl
// Self-checking bench for timer_irq_ctrl. A behavioural model tracks the
// expected outputs from the event rules; directed scenarios are followed by
// a randomized run, and every cycle all outputs are compared.
// ---------------------------------------------------------------------------
module tb_timer_irq_ctrl;

   localparam int CNT_W   = 32;
   localparam int EVT_W   = 4;
   localparam int PULSE_W = 4;
   localparam int EVT_MAX = (1 << EVT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   timer_irq_ctrl_if #(.CNT_W(CNT_W), .EVT_W(EVT_W)) bus ();

   timer_irq_ctrl #(
      .CNT_W   (CNT_W),
      .EVT_W   (EVT_W),
      .PULSE_W (PULSE_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   // Reference model state: last counter value seen, sticky status, the
   // delayed interrupt, the last expiry edge (pulse_out is "within PULSE_W
   // edges of the latest expiry") and the expiry count as an integer.
   logic [CNT_W-1:0] m_prev;
   logic [1:0]       m_status;
   logic             m_irq;
   logic             m_exp_pulse;
   int               m_evt;
   int               edge_no;
   int               last_exp;
   bit               have_exp;
   int               pulse_hi;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_prev      = '1;
      m_status    = 2'b00;
      m_irq       = 1'b0;
      m_exp_pulse = 1'b0;
      m_evt       = 0;
      have_exp    = 1'b0;
   endtask

   // One rising edge of the model, evaluated from the inputs that were
   // present during the cycle that ends at this edge.
   task automatic modelEdge();
      bit exp_e;
      bit cmp_e;
      exp_e = (bus.cnt == 0) && (m_prev != 0);
      cmp_e = (bus.cnt == bus.cfg_cmp) && (m_prev != bus.cfg_cmp);
      edge_no++;
      m_irq       = |(m_status & bus.irq_en);
      m_status    = (m_status & ~bus.sts_clr) | {cmp_e, exp_e};
      m_exp_pulse = exp_e;
      if (exp_e) begin
         have_exp = 1'b1;
         last_exp = edge_no;
      end
      if (bus.evt_clr)
         m_evt = exp_e ? 1 : 0;
      else if (exp_e)
         m_evt = (m_evt < EVT_MAX) ? m_evt + 1 : EVT_MAX;
      m_prev = bus.cnt;
   endtask

   task automatic checkOutput(input string tag);
      logic exp_pulse_out;
      exp_pulse_out = have_exp && ((edge_no - last_exp) < PULSE_W);
      check({tag, ".status"},       32'(bus.status),       32'(m_status));
      check({tag, ".irq"},          32'(bus.irq),          32'(m_irq));
      check({tag, ".expire_pulse"}, 32'(bus.expire_pulse), 32'(m_exp_pulse));
      check({tag, ".pulse_out"},    32'(bus.pulse_out),    32'(exp_pulse_out));
      check({tag, ".evt_count"},    32'(bus.evt_count),    32'(m_evt));
   endtask

   // Drive one cycle of inputs at the falling edge, let the rising edge
   // happen, then sample on the next falling edge.
   task automatic applyStimulus(input logic [31:0] cnt_v, input logic [31:0] cmp_v,
                                input logic [1:0] en_v, input logic [1:0] clr_v,
                                input logic eclr_v, input string tag);
      bus.cnt     = cnt_v;
      bus.cfg_cmp = cmp_v;
      bus.irq_en  = en_v;
      bus.sts_clr = clr_v;
      bus.evt_clr = eclr_v;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput(tag);
      if (bus.pulse_out === 1'b1) pulse_hi++;
   endtask

   initial begin
      logic [31:0] rnd_cmp;
      $display("[TB] timer_irq_ctrl bench start");
      edge_no  = 0;
      last_exp = 0;
      pulse_hi = 0;
      modelReset();
      bus.cnt     = 32'd3;
      bus.cfg_cmp = 32'd100;
      bus.irq_en  = 2'b01;
      bus.sts_clr = 2'b00;
      bus.evt_clr = 1'b0;

      // Reset state
      #1;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Expiry: 3,2,1,0,0,0...
      applyStimulus(3, 100, 2'b01, 2'b00, 1'b0, "exp_3");
      applyStimulus(2, 100, 2'b01, 2'b00, 1'b0, "exp_2");
      applyStimulus(1, 100, 2'b01, 2'b00, 1'b0, "exp_1");
      pulse_hi = 0;
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "exp_0a");
      check("exp_strobe_n1", 32'(bus.expire_pulse), 1);
      check("exp_status_n1", 32'(bus.status), 32'b01);
      check("exp_irq_n1",    32'(bus.irq), 0);
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "exp_0b");
      check("exp_irq_n2",    32'(bus.irq), 1);
      check("exp_strobe_n2", 32'(bus.expire_pulse), 0);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "exp_park");
      check("exp_pulse_len", 32'(pulse_hi), PULSE_W);
      check("exp_evt_count", 32'(bus.evt_count), 1);

      // Compare: cfg_cmp=5, 7,6,5,5,4 with only the compare enable
      applyStimulus(0, 5, 2'b10, 2'b11, 1'b0, "cmp_clr");
      applyStimulus(7, 5, 2'b10, 2'b00, 1'b0, "cmp_7");
      applyStimulus(6, 5, 2'b10, 2'b00, 1'b0, "cmp_6");
      applyStimulus(5, 5, 2'b10, 2'b00, 1'b0, "cmp_5a");
      check("cmp_status_set", 32'(bus.status), 32'b10);
      applyStimulus(5, 5, 2'b10, 2'b00, 1'b0, "cmp_5b");
      applyStimulus(4, 5, 2'b10, 2'b00, 1'b0, "cmp_4");
      check("cmp_irq",    32'(bus.irq), 1);
      check("cmp_status", 32'(bus.status), 32'b10);

      // Clear/set collision on the expiry bit
      applyStimulus(1, 100, 2'b01, 2'b11, 1'b0, "col_clr");
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "col_exp");
      applyStimulus(1, 100, 2'b01, 2'b00, 1'b0, "col_1");
      applyStimulus(0, 100, 2'b01, 2'b01, 1'b0, "col_both");
      check("col_status_kept", 32'(bus.status), 32'b01);
      check("col_irq_kept",    32'(bus.irq), 1);
      applyStimulus(0, 100, 2'b01, 2'b01, 1'b0, "col_clr_only");
      check("col_status_drop", 32'(bus.status), 32'b00);
      check("col_irq_lag",     32'(bus.irq), 1);
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "col_after");
      check("col_irq_drop",    32'(bus.irq), 0);

      // Saturation: 20 expiries into a 4-bit counter
      applyStimulus(1, 100, 2'b01, 2'b00, 1'b1, "sat_clr");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "sat_0");
         applyStimulus(1, 100, 2'b01, 2'b00, 1'b0, "sat_1");
      end
      check("sat_stop", 32'(bus.evt_count), EVT_MAX);
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b1, "sat_clr_exp");
      check("sat_clr_with_exp", 32'(bus.evt_count), 1);

      // Retrigger: expiries two cycles apart give one 6-cycle pulse
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 100, 2'b01, 2'b00, 1'b0, "rt_drain");
      pulse_hi = 0;
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "rt_0a");
      applyStimulus(1, 100, 2'b01, 2'b00, 1'b0, "rt_1");
      applyStimulus(0, 100, 2'b01, 2'b00, 1'b0, "rt_0b");
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 100, 2'b01, 2'b00, 1'b0, "rt_tail");
      check("rt_pulse_len", 32'(pulse_hi), 6);

      // Reset mid-pulse with both status bits set (cfg_cmp=0)
      applyStimulus(1, 0, 2'b11, 2'b00, 1'b0, "rst_1");
      applyStimulus(0, 0, 2'b11, 2'b00, 1'b0, "rst_0");
      check("rst_pre_status", 32'(bus.status), 32'b11);
      check("rst_pre_pulse",  32'(bus.pulse_out), 1);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_mid");
      bus.cnt = 0;
      #2;
      rst_n = 1'b1;
      applyStimulus(0, 0, 2'b11, 2'b00, 1'b0, "rst_rel");
      check("rst_rel_strobe", 32'(bus.expire_pulse), 1);
      check("rst_rel_status", 32'(bus.status), 32'b11);

      // Randomized run over a small counter range so events are frequent
      rnd_cmp = 32'($urandom_range(0, 3));
      for (int i = 0; i < 300; i++) begin
         logic [1:0] clr_r;
         if ((i % 25) == 0) rnd_cmp = 32'($urandom_range(0, 3));
         clr_r = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         applyStimulus(32'($urandom_range(0, 3)), rnd_cmp, 2'($urandom_range(0, 3)),
                       clr_r, ($urandom_range(0, 15) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
